hazard_ctrl: RTL

- Pipeline hazard controller that produces the flush/stall controls consumed by the IF/ID and ID/EX pipeline registers (including ID_EX_Flush) and the PC write enable.
- Watches the instruction in ID and the control fields already latched in ID/EX and EX/MEM.
- Inserts load-use and jump-register stall bubbles, and squashes wrong-path instructions on a taken branch or jump.
- Holds a small FSM for multi-cycle stalls and saturating stall/flush event counters for debug.

---
 rtl/hazard_ctrl_pkg.sv | 27 ++
 rtl/hazard_ctrl_sat_counter.sv | 34 +++
 rtl/hazard_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
/*****************************************************************
 * Module : hazard_ctrl_pkg
 * Brief  : Shared state encoding and register constants for the
 *          pipeline hazard controller.
 * Rev    : 1.0  initial release
 *****************************************************************/
`default_nettype none

package hazard_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    STALL2 = 1'b1
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // $0 is hard-wired, so a producer writing it never creates a hazard.
  function automatic logic reg_match(input logic       uses,
                                     input logic [4:0] src,
                                     input logic [4:0] dst);
    return uses && (src == dst) && (dst != REG_ZERO);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_sat_counter.sv
/*****************************************************************
 * Module : sat_counter
 * Brief  : Up counter that sticks at all-ones instead of wrapping.
 * Rev    : 1.0  initial release
 *****************************************************************/
`default_nettype none

module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] C_MAX = '1;
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && (r_count != C_MAX)) begin
      r_count <= r_count + C_ONE;
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
/*****************************************************************
 * Module : hazard_ctrl
 * Brief  : Load-use / jump-register stall and branch/jump flush
 *          control with saturating debug event counters.
 * Rev    : 1.0  initial release
 *****************************************************************/
`default_nettype none

module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_RegisterRs,
  input  logic [4:0]       ID_RegisterRt,
  input  logic             ID_UsesRs,
  input  logic             ID_UsesRt,
  input  logic             ID_isJump,
  input  logic             ID_isJR,
  input  logic             EX_MemRd,
  input  logic             EX_RegWr,
  input  logic [4:0]       EX_RegisterDst,
  input  logic             MEM_MemRd,
  input  logic [4:0]       MEM_RegisterDst,
  input  logic             EX_BranchTaken,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             PCSrc_Branch,
  output logic             Stall,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  state_t r_state;
  state_t w_next_state;

  logic       w_load_use;
  logic       w_jr_ex_match;
  logic       w_jr_mem_match;
  logic       w_need2;
  logic       w_need1;

  assign w_load_use     = EX_MemRd &&
                          (reg_match(ID_UsesRs, ID_RegisterRs, EX_RegisterDst) ||
                           reg_match(ID_UsesRt, ID_RegisterRt, EX_RegisterDst));
  assign w_jr_ex_match  = reg_match(ID_isJR, ID_RegisterRs, EX_RegisterDst);
  assign w_jr_mem_match = reg_match(ID_isJR, ID_RegisterRs, MEM_RegisterDst);

  // A jr behind a load needs the value past MEM, hence the extra cycle.
  assign w_need2 = w_jr_ex_match && EX_MemRd;
  assign w_need1 = w_load_use ||
                   (w_jr_ex_match && EX_RegWr) ||
                   (w_jr_mem_match && MEM_MemRd);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = RUN;
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    PCSrc_Branch = 1'b0;
    Stall        = 1'b0;

    if (reset) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Flush  = 1'b1;
    end else if (EX_BranchTaken) begin
      // ID holds a wrong-path instruction, so its hazards are irrelevant.
      PCSrc_Branch = 1'b1;
      IF_ID_Flush  = 1'b1;
      ID_EX_Flush  = 1'b1;
    end else if ((r_state == STALL2) || w_need1 || w_need2) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Flush  = 1'b1;
      Stall        = 1'b1;
      if ((r_state == RUN) && w_need2) begin
        w_next_state = STALL2;
      end
    end else if (ID_isJump || ID_isJR) begin
      IF_ID_Flush  = 1'b1;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (Stall),
    .count (StallCount)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (IF_ID_Flush),
    .count (FlushCount)
  );

endmodule

`default_nettype wire
